// File: rtl/lift_pkg.sv
// Shared state encoding and default timing constants for the SCAN lift controller.
package lift_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_MOVE_UP    = 3'd1;
   localparam logic [2:0] ST_MOVE_DOWN  = 3'd2;
   localparam logic [2:0] ST_DOOR_OPEN  = 3'd3;
   localparam logic [2:0] ST_DOOR_CLOSE = 3'd4;

   typedef enum logic [2:0] {
      StIdle      = ST_IDLE,
      StMoveUp    = ST_MOVE_UP,
      StMoveDown  = ST_MOVE_DOWN,
      StDoorOpen  = ST_DOOR_OPEN,
      StDoorClose = ST_DOOR_CLOSE
   } lift_state_e;

   localparam int unsigned DEF_NUM_FLOORS    = 8;
   localparam int unsigned DEF_TRAVEL_CYCLES = 3;
   localparam int unsigned DEF_DOOR_CYCLES   = 4;

endpackage

// File: rtl/lift_call_queue.sv
// Pending-call register with set/clear and direction reductions relative to the car position.
module lift_call_queue
   import lift_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_valid,
   input  logic [FLOOR_W-1:0]    set_floor,
   input  logic                  clr_valid,
   input  logic [FLOOR_W-1:0]    clr_floor,
   input  logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  at_floor,
   output logic                  any_above,
   output logic                  any_below
);

   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [NUM_FLOORS-1:0] set_mask, clr_mask;

   // Clear wins over set so a call for the floor being served on this edge is absorbed.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_valid && (32'(set_floor) < NUM_FLOORS)) set_mask[set_floor] = 1'b1;
      if (clr_valid) clr_mask[clr_floor] = 1'b1;
      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pending_q <= '0;
      else      pending_q <= pending_d;
   end

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (pending_q[i] && (i > int'(current_floor))) any_above = 1'b1;
         if (pending_q[i] && (i < int'(current_floor))) any_below = 1'b1;
      end
      at_floor = pending_q[current_floor];
   end

   assign pending = pending_q;

endmodule

// File: rtl/lift_scan_ctrl.sv
// Multi-floor SCAN lift controller: FSM, travel/door timers, motor and door outputs.
// Optional emergency stop input enabled by defining LIFT_ESTOP_EN.
module lift_scan_ctrl
   import lift_pkg::*;
#(
   parameter int unsigned NUM_FLOORS    = DEF_NUM_FLOORS,
   parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef LIFT_ESTOP_EN
   input  logic                  estop,
`endif
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  motor_up,
   output logic                  motor_down,
   output logic                  door_open,
   output logic                  door_close,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int unsigned TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
   localparam int unsigned DOOR_W   = $clog2(DOOR_CYCLES + 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   lift_state_e          state_q, state_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d;
   logic                 dir_q, dir_d;
   logic [TRAVEL_W-1:0]  travel_q, travel_d;
   logic [DOOR_W-1:0]    door_q, door_d;

   logic                 halt;
   logic                 door_call;
   logic                 set_valid;
   logic                 clr_valid;
   logic [FLOOR_W-1:0]   clr_floor;
   logic                 at_floor, any_above, any_below;
   logic                 travel_done, door_done;

`ifdef LIFT_ESTOP_EN
   assign halt = estop;
`else
   assign halt = 1'b0;
`endif

   // A call for the open floor only extends the dwell; it never re-queues the floor.
   assign door_call   = req_valid && (state_q == StDoorOpen) && (req_floor == floor_q);
   assign set_valid   = req_valid && !door_call;
   assign travel_done = (travel_q == TRAVEL_W'(TRAVEL_CYCLES - 1));
   assign door_done   = (door_q == DOOR_W'(DOOR_CYCLES - 1));

   lift_call_queue #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_call_queue (
      .clk           (clk),
      .rst           (rst),
      .set_valid     (set_valid),
      .set_floor     (req_floor),
      .clr_valid     (clr_valid),
      .clr_floor     (clr_floor),
      .current_floor (floor_q),
      .pending       (pending),
      .at_floor      (at_floor),
      .any_above     (any_above),
      .any_below     (any_below)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         floor_q  <= '0;
         dir_q    <= 1'b1;
         travel_q <= '0;
         door_q   <= '0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         travel_q <= travel_d;
         door_q   <= door_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      travel_d  = travel_q;
      door_d    = door_q;
      clr_valid = 1'b0;
      clr_floor = floor_q;
      // Emergency stop freezes everything except call capture.
      if (!halt) begin
         unique case (state_q)
            StIdle: begin
               travel_d = '0;
               door_d   = '0;
               if (at_floor) begin
                  state_d   = StDoorOpen;
                  clr_valid = 1'b1;
               end else if (any_above) begin
                  state_d = StMoveUp;
                  dir_d   = 1'b1;
               end else if (any_below) begin
                  state_d = StMoveDown;
                  dir_d   = 1'b0;
               end
            end
            StMoveUp, StMoveDown: begin
               if (travel_done) begin
                  travel_d = '0;
                  if ((state_q == StMoveUp && floor_q == TOP_FLOOR) ||
                      (state_q == StMoveDown && floor_q == '0)) begin
                     state_d = StIdle;
                  end else begin
                     floor_d = (state_q == StMoveUp) ? floor_q + 1'b1 : floor_q - 1'b1;
                     if (pending[floor_d]) begin
                        state_d   = StDoorOpen;
                        door_d    = '0;
                        clr_valid = 1'b1;
                        clr_floor = floor_d;
                     end
                  end
               end else begin
                  travel_d = travel_q + 1'b1;
               end
            end
            StDoorOpen: begin
               if (door_call) begin
                  door_d = '0;
               end else if (door_done) begin
                  state_d = StDoorClose;
                  door_d  = '0;
               end else begin
                  door_d = door_q + 1'b1;
               end
            end
            StDoorClose: begin
               travel_d = '0;
               if (dir_q ? any_above : any_below) begin
                  state_d = dir_q ? StMoveUp : StMoveDown;
               end else if (dir_q ? any_below : any_above) begin
                  state_d = dir_q ? StMoveDown : StMoveUp;
                  dir_d   = !dir_q;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      motor_up   = (state_q == StMoveUp) && !halt;
      motor_down = (state_q == StMoveDown) && !halt;
      door_open  = (state_q == StDoorOpen) || (halt && state_q == StIdle);
      door_close = !door_open;
      busy       = (state_q != StIdle) || (|pending);
   end

   assign current_floor = floor_q;
   assign dir_up        = dir_q;

endmodule
